// File: rtl/dmem_sram_bridge.sv
// Data-side bridge from the M-stage load/store unit to an SRAM-like port.
// One request/response transaction per memory instruction; stalls M until the response arrives.
module dmem_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_en_i,
  input  logic [DATA_W/8-1:0]   mem_wen_i,
  input  logic [1:0]            mem_size_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic                  except_i,
  input  logic                  stall_all_i,
  output logic                  mem_stall_o,
  output logic [DATA_W-1:0]     mem_rdata_o,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [DATA_W/8-1:0]   data_wstrb,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_W-1:0]     data_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // kseg0/kseg1 are unmapped windows onto the low 512 MB of physical space
  function automatic logic [ADDR_W-1:0] va2pa(input logic [ADDR_W-1:0] va);
    logic [ADDR_W-1:0] pa;
    if (va[ADDR_W-1 -: 2] == 2'b10) begin
      pa = {3'b000, va[ADDR_W-4:0]};
    end else begin
      pa = va;
    end
    return pa;
  endfunction

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic                  wr_q, wr_d;
  logic [1:0]            size_q, size_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  start_s;
  logic                  stall_s;

  assign start_s = mem_en_i & ~except_i;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stall_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_s = start_s;
        if (start_s) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          wr_d    = |mem_wen_i;
          size_d  = mem_size_i;
          wstrb_d = mem_wen_i;
          addr_d  = va2pa(mem_addr_i);
          wdata_d = mem_wdata_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        stall_s = 1'b1;
        if (data_addr_ok) begin
          req_d   = 1'b0;
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        stall_s = 1'b1;
        // Stores capture the response word too; M simply ignores it
        if (data_data_ok) begin
          rdata_d = data_rdata;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        stall_s = 1'b0;
        if (stall_all_i) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Gated by reset so an M-stage request cannot stall the pipe while the bridge is held
  assign mem_stall_o = resetn & stall_s;
  assign mem_rdata_o = rdata_q;
  assign data_req    = req_q;
  assign data_wr     = wr_q;
  assign data_size   = size_q;
  assign data_wstrb  = wstrb_q;
  assign data_addr   = addr_q;
  assign data_wdata  = wdata_q;

endmodule
